// File: rtl/axi_pkg.sv
// Shared AXI constants and the FSM state encodings of the RAM slave.
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_WAIT = 2'd2,
        W_RESP = 2'd3
    } w_state_t;

endpackage

// File: rtl/ram_sdp.sv
// Simple-dual-port word RAM: one byte-masked write port, one synchronous read port.
// A read and a write to the same word on the same edge returns the old word.
module ram_sdp #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    input  logic [3:0]        wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // Byte-masked write; contents are never reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en[b]) begin
                mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Registered read; only the output register is cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 32'h0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 slave memory model with independent fixed-latency read and write engines.
// Handshakes: a transfer happens on a rising edge where both valid and ready are
// high; the slave holds rvalid/rdata/rlast/rresp and bvalid/bid/bresp stable
// until the matching ready is seen.
module axi_ram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    // Burst type, write ID and the aliased/sub-word address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{arburst, awburst, wid, araddr[31:ADDR_W+2], araddr[1:0],
                             awaddr[31:ADDR_W+2], awaddr[1:0]};

    r_state_t          r_state, r_state_nxt;
    logic [3:0]        r_id;
    logic [ADDR_W-1:0] r_idx;
    logic [7:0]        r_beats;
    logic [7:0]        r_lat;
    logic              r_err;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;

    w_state_t          w_state, w_state_nxt;
    logic [3:0]        w_id;
    logic [ADDR_W-1:0] w_idx;
    logic [7:0]        w_beats;
    logic [7:0]        w_lat;
    logic              w_err;
    logic [3:0]        ram_wr_en;

    ram_sdp #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (aclk),
        .rst     (areset),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (rdata),
        .wr_en   (ram_wr_en),
        .wr_addr (w_idx),
        .wr_data (wdata)
    );

    assign rid = r_id;
    assign bid = w_id;

    // Read engine next state, channel outputs and RAM read request.
    always_comb begin
        r_state_nxt = r_state;
        arready     = 1'b0;
        rvalid      = 1'b0;
        rlast       = 1'b0;
        rresp       = AXI_RESP_OKAY;
        ram_rd_en   = 1'b0;
        ram_rd_addr = r_idx;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) r_state_nxt = R_WAIT;
            end
            R_WAIT: begin
                if (r_lat == 8'd0) begin
                    ram_rd_en   = 1'b1;
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (r_beats == 8'd0);
                rresp  = r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                if (rready) begin
                    if (r_beats == 8'd0) begin
                        r_state_nxt = R_IDLE;
                    end else begin
                        // Fetch the next word now so beats stream at one per cycle.
                        ram_rd_en   = 1'b1;
                        ram_rd_addr = r_idx + 1'b1;
                    end
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read engine state register and burst bookkeeping.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= R_IDLE;
            r_id    <= 4'h0;
            r_idx   <= '0;
            r_beats <= 8'd0;
            r_lat   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= r_state_nxt;
            case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        r_id    <= arid;
                        r_idx   <= araddr[ADDR_W+1:2];
                        r_beats <= arlen;
                        r_lat   <= 8'(RD_LAT - 1);
                        r_err   <= (arsize != AXI_SIZE_4B);
                    end
                end
                R_WAIT: begin
                    if (r_lat != 8'd0) r_lat <= r_lat - 8'd1;
                end
                R_DATA: begin
                    if (rready && r_beats != 8'd0) begin
                        r_idx   <= r_idx + 1'b1;
                        r_beats <= r_beats - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write engine next state, channel outputs and RAM byte enables.
    always_comb begin
        w_state_nxt = w_state;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        bresp       = AXI_RESP_OKAY;
        ram_wr_en   = 4'b0000;
        case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    ram_wr_en = wstrb;
                    if (w_beats == 8'd0) w_state_nxt = W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_lat == 8'd0) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = w_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                if (bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write engine state register; the beat count, not wlast, ends the burst.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            w_id    <= 4'h0;
            w_idx   <= '0;
            w_beats <= 8'd0;
            w_lat   <= 8'd0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            case (w_state)
                W_IDLE: begin
                    if (awvalid) begin
                        w_id    <= awid;
                        w_idx   <= awaddr[ADDR_W+1:2];
                        w_beats <= awlen;
                        w_err   <= (awsize != AXI_SIZE_4B);
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        w_idx <= w_idx + 1'b1;
                        if (wlast != (w_beats == 8'd0)) w_err <= 1'b1;
                        if (w_beats == 8'd0) w_lat <= 8'(WR_LAT - 1);
                        else                 w_beats <= w_beats - 8'd1;
                    end
                end
                W_WAIT: begin
                    if (w_lat != 8'd0) w_lat <= w_lat - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: single-beat vector table plus burst,
// wrap, collision and mid-transaction reset sequences.
module tb_axi_ram_slave;
    import axi_pkg::*;

    localparam int ADDR_W = 16;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic        aclk, areset;
    logic [3:0]  arid;   logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
    logic [1:0]  arburst; logic arvalid, arready;
    logic [3:0]  rid;    logic [31:0] rdata;  logic [1:0] rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;   logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
    logic [1:0]  awburst; logic awvalid, awready;
    logic [3:0]  wid;    logic [31:0] wdata;  logic [3:0] wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;    logic [1:0] bresp;   logic bvalid, bready;

    axi_ram_slave #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // Clock and watchdog.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Results captured by the driver tasks.
    logic [31:0] wbuf [16];
    logic [3:0]  got_bid;
    logic [1:0]  got_bresp;
    int          got_wlat;
    logic [31:0] got_rdata [16];
    logic        got_rlast [16];
    logic [1:0]  got_rresp [16];
    logic [3:0]  got_rid;
    int          got_rlat;
    int          got_arlow;
    int          got_beats;
    logic [31:0] exp_q [$];

    // Write driver: AW, then len+1 W beats from wbuf, then collect B.
    task automatic wr_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [3:0] strb, input bit bad_last);
        int n;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = 2'b01; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        check("awready_wait", 32'(awready), 32'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb; wid = id;
            wlast = (i == int'(len)) ^ bad_last;
            n = 0;
            while (!wready && n < 50) begin @(negedge aclk); n++; end
            if (!wready) check("wready_wait", 32'(wready), 32'd1);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        got_wlat = 0;
        while (!bvalid && got_wlat < 50) begin got_wlat++; @(negedge aclk); end
        got_bid = bid; got_bresp = bresp;
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    // Read driver: AR, then collect len+1 beats with rready following pat (LSB first).
    task automatic rd_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [15:0] pat);
        int n, k;
        bit held;
        logic [31:0] held_data;
        @(negedge aclk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = 2'b01; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        check("arready_wait", 32'(arready), 32'd1);
        @(negedge aclk);
        arvalid = 1'b0;
        got_rlat = 0; got_arlow = 0;
        while (!rvalid && got_rlat < 50) begin
            got_rlat++;
            if (!arready) got_arlow++;
            @(negedge aclk);
        end
        got_rid = rid; got_beats = 0; k = 0; held = 1'b0; held_data = 32'h0;
        while (got_beats <= int'(len) && k < 100) begin
            rready = pat[k % 16];
            if (rvalid) begin
                if (held) check("rdata_stable", rdata, held_data);
                if (rready) begin
                    got_rdata[got_beats] = rdata;
                    got_rlast[got_beats] = rlast;
                    got_rresp[got_beats] = rresp;
                    got_beats++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_data = rdata;
                end
            end
            k++;
            @(negedge aclk);
        end
        rready = 1'b0;
    endtask

    typedef struct {
        bit          is_wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int n;
        vecs[0]  = '{1'b1, 4'h5, 32'h0000_0080, 3'b010, 32'hFFFF_FFFF, 4'hF, AXI_RESP_OKAY,   32'h0};
        vecs[1]  = '{1'b1, 4'h5, 32'h0000_0080, 3'b010, 32'h1122_3344, 4'h5, AXI_RESP_OKAY,   32'h0};
        vecs[2]  = '{1'b0, 4'h3, 32'h0000_0080, 3'b010, 32'h0,         4'h0, AXI_RESP_OKAY,   32'hFF22_FF44};
        vecs[3]  = '{1'b1, 4'h1, 32'h0000_0040, 3'b010, 32'hDEAD_BEEF, 4'hF, AXI_RESP_OKAY,   32'h0};
        vecs[4]  = '{1'b0, 4'h3, 32'h0000_0040, 3'b010, 32'h0,         4'h0, AXI_RESP_OKAY,   32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 4'h2, 32'h0000_0044, 3'b001, 32'hA5A5_A5A5, 4'hF, AXI_RESP_SLVERR, 32'h0};
        vecs[6]  = '{1'b0, 4'h7, 32'h0000_0044, 3'b010, 32'h0,         4'h0, AXI_RESP_OKAY,   32'hA5A5_A5A5};
        vecs[7]  = '{1'b0, 4'h6, 32'h0000_0044, 3'b000, 32'h0,         4'h0, AXI_RESP_SLVERR, 32'hA5A5_A5A5};
        vecs[8]  = '{1'b1, 4'h9, 32'h0000_0047, 3'b010, 32'h1234_5678, 4'h8, AXI_RESP_OKAY,   32'h0};
        vecs[9]  = '{1'b0, 4'hF, 32'h0000_0044, 3'b010, 32'h0,         4'h0, AXI_RESP_OKAY,   32'h12A5_A5A5};
        vecs[10] = '{1'b0, 4'h4, 32'hABC4_0044, 3'b010, 32'h0,         4'h0, AXI_RESP_OKAY,   32'h12A5_A5A5};

        // Reset and idle inputs.
        areset = 1'b1;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rlast",   32'(rlast),   32'd0);
        check("rst_ids",     32'({rid, bid}), 32'd0);
        check("rst_resps",   32'({rresp, bresp}), 32'd0);
        check("rst_rdata",   rdata, 32'd0);

        // Single-beat vector table.
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].is_wr) begin
                wbuf[0] = vecs[v].data;
                wr_send(vecs[v].id, vecs[v].addr, 8'd0, vecs[v].size, vecs[v].strb, 1'b0);
                check($sformatf("v%0d_bid", v),   32'(got_bid),   32'(vecs[v].id));
                check($sformatf("v%0d_bresp", v), 32'(got_bresp), 32'(vecs[v].exp_resp));
                check($sformatf("v%0d_wlat", v),  32'(got_wlat),  32'(WR_LAT));
            end else begin
                rd_send(vecs[v].id, vecs[v].addr, 8'd0, vecs[v].size, 16'hFFFF);
                check($sformatf("v%0d_rid", v),    32'(got_rid),      32'(vecs[v].id));
                check($sformatf("v%0d_rdata", v),  got_rdata[0],      vecs[v].exp_data);
                check($sformatf("v%0d_rresp", v),  32'(got_rresp[0]), 32'(vecs[v].exp_resp));
                check($sformatf("v%0d_rlast", v),  32'(got_rlast[0]), 32'd1);
                check($sformatf("v%0d_rlat", v),   32'(got_rlat),     32'(RD_LAT));
                check($sformatf("v%0d_arlow", v),  32'(got_arlow),    32'(RD_LAT));
            end
        end

        // 4-beat burst with rready stalls.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA000_0000 + 32'(i);
        wr_send(4'h8, 32'h100, 8'd3, 3'b010, 4'hF, 1'b0);
        check("burst_wr_bresp", 32'(got_bresp), 32'(AXI_RESP_OKAY));
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA000_0000 + 32'(i));
        rd_send(4'hA, 32'h100, 8'd3, 3'b010, 16'hFFED);
        check("burst_beats", 32'(got_beats), 32'd4);
        for (int b = 0; b < 4; b++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check($sformatf("burst_data%0d", b), got_rdata[b], e);
            check($sformatf("burst_last%0d", b), 32'(got_rlast[b]), (b == 3) ? 32'd1 : 32'd0);
        end

        // wlast disagreeing with the beat count.
        wbuf[0] = 32'h0101_0101; wbuf[1] = 32'h0202_0202;
        wr_send(4'h3, 32'h200, 8'd1, 3'b010, 4'hF, 1'b1);
        check("wlast_err_bresp", 32'(got_bresp), 32'(AXI_RESP_SLVERR));
        check("wlast_err_bid",   32'(got_bid),   32'h3);

        // Burst wrap at the top of the word space.
        wbuf[0] = 32'hCAFE_F00D;
        wr_send(4'h1, 32'h0003_FFFC, 8'd0, 3'b010, 4'hF, 1'b0);
        wbuf[0] = 32'h0BAD_C0DE;
        wr_send(4'h1, 32'h0000_0000, 8'd0, 3'b010, 4'hF, 1'b0);
        rd_send(4'h2, 32'h0003_FFFC, 8'd1, 3'b010, 16'hFFFF);
        check("wrap_data0", got_rdata[0], 32'hCAFE_F00D);
        check("wrap_data1", got_rdata[1], 32'h0BAD_C0DE);
        check("wrap_last0", 32'(got_rlast[0]), 32'd0);
        check("wrap_last1", 32'(got_rlast[1]), 32'd1);

        // Read sample and write to the same word on the same edge.
        wbuf[0] = 32'h0101_0101;
        wr_send(4'h0, 32'h0C0, 8'd0, 3'b010, 4'hF, 1'b0);
        @(negedge aclk);
        arid = 4'h1; araddr = 32'h0C0; arlen = 0; arsize = 3'b010; arvalid = 1'b1;
        awid = 4'h2; awaddr = 32'h0C0; awlen = 0; awsize = 3'b010; awvalid = 1'b1;
        check("conc_ready", 32'({arready, awready}), 32'd3);
        @(negedge aclk);
        arvalid = 1'b0; awvalid = 1'b0;
        @(negedge aclk);
        wvalid = 1'b1; wdata = 32'h0202_0202; wstrb = 4'hF; wlast = 1'b1;
        check("conc_wready", 32'(wready), 32'd1);
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0;
        check("conc_rvalid", 32'(rvalid), 32'd1);
        check("conc_old_data", rdata, 32'h0101_0101);
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge aclk); n++; end
        check("conc_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        rd_send(4'h1, 32'h0C0, 8'd0, 3'b010, 16'hFFFF);
        check("conc_new_data", got_rdata[0], 32'h0202_0202);

        // Reset with the read engine in R_DATA and the write engine in W_WAIT.
        @(negedge aclk);
        arid = 4'hC; araddr = 32'h100; arlen = 8'd3; arsize = 3'b010; arvalid = 1'b1; rready = 1'b0;
        @(negedge aclk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge aclk); n++; end
        check("rst_mid_rvalid_before", 32'(rvalid), 32'd1);
        awid = 4'hD; awaddr = 32'h140; awlen = 0; awsize = 3'b010; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'h7777_7777; wstrb = 4'hF; wlast = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0;
        check("rst_mid_bvalid_before", 32'(bvalid), 32'd0);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        check("rst_mid_rvalid",  32'(rvalid),  32'd0);
        check("rst_mid_bvalid",  32'(bvalid),  32'd0);
        check("rst_mid_arready", 32'(arready), 32'd1);
        check("rst_mid_awready", 32'(awready), 32'd1);
        check("rst_mid_wready",  32'(wready),  32'd0);
        check("rst_mid_ids",     32'({rid, bid}), 32'd0);
        check("rst_mid_rdata",   rdata, 32'd0);
        rd_send(4'h5, 32'h140, 8'd0, 3'b010, 16'hFFFF);
        check("post_rst_rd_data", got_rdata[0], 32'h7777_7777);
        check("post_rst_rd_rid",  32'(got_rid), 32'h5);
        check("post_rst_rd_last", 32'(got_rlast[0]), 32'd1);
        wbuf[0] = 32'h1357_2468;
        wr_send(4'h6, 32'h140, 8'd0, 3'b010, 4'hF, 1'b0);
        check("post_rst_wr_bid",   32'(got_bid),   32'h6);
        check("post_rst_wr_bresp", 32'(got_bresp), 32'(AXI_RESP_OKAY));
        rd_send(4'h7, 32'h140, 8'd0, 3'b010, 16'hFFFF);
        check("post_rst_readback", got_rdata[0], 32'h1357_2468);

        repeat (2) @(negedge aclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
